dm_responder: RTL and testbench



---
 rtl/dm_responder.sv | 134 +++++++++++++
 tb/tb_dm_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - data-memory responder: valid/ready request, programmable wait states, byte-enabled word RAM
`timescale 1ns/1ps
module dm_responder #(
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 1024,
    parameter int WAIT_RD = 2,
    parameter int WAIT_WR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      WAIT_RD_C = 4'(WAIT_RD);
    localparam logic [3:0]      WAIT_WR_C = 4'(WAIT_WR);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              access;
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    logic [31:0] mem [DEPTH];

    assign in_range = ({1'b0, addr_q} < DEPTH_C);
    assign idx      = addr_q[IDX_W-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        access      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = req_we ? WAIT_WR_C : WAIT_RD_C;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Access edge: the RAM write and the read capture happen here.
                    access      = 1'b1;
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rdata_d     = (!we_q && in_range) ? mem[idx] : 32'd0;
                    err_d       = !in_range;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // RAM is deliberately not reset; reset forces IDLE so no access can fire.
    always_ff @(posedge clk) begin
        if (access && we_q && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - directed scoreboard bench for dm_responder
`timescale 1ns/1ps
module tb_dm_responder;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 512;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = 32'd0;
    logic [3:0]        req_be = 4'd0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              busy;

    dm_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_RD(2), .WAIT_WR(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        exp_t e;
        e.err   = (int'(addr) >= DEPTH);
        e.lat   = we ? 2 : 3;
        e.rdata = 32'd0;
        if (!e.err) begin
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) model[addr][8*i +: 8] = wdata[8*i +: 8];
            end else begin
                e.rdata = model[addr];
            end
        end
        sb.push_back(e);
    endtask

    // Returns #1 after the accepting edge.
    task automatic issue(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        int k;
        @(negedge clk);
        for (k = 0; k < 20 && !req_ready; k++) @(negedge clk);
        if (k == 20) check("ready_timeout", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("ready_drop", {31'd0, req_ready}, 32'd0);
        push_exp(we, addr, wdata, be);
    endtask

    task automatic wait_rsp(input string tag);
        int   lat;
        exp_t e;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (rsp_valid) break;
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_lat"}, lat, e.lat);
            check({tag, "_rdata"}, rsp_rdata, e.rdata);
            check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
        end
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, "_vld_clr"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic txn(input string tag, input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
        issue(we, addr, wdata, be);
        wait_rsp(tag);
        handshake(tag);
    endtask

    initial begin
        logic [31:0] held;
        #3;
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        txn("init0", 1'b1, 10'h000, 32'hA5A5A5A5, 4'hF);
        txn("init10", 1'b1, 10'h010, 32'h00000000, 4'hF);
        txn("wr5", 1'b1, 10'h005, 32'hDEADBEEF, 4'hF);
        txn("rd5", 1'b0, 10'h005, 32'h0, 4'h0);
        txn("wr5_b0", 1'b1, 10'h005, 32'h00000011, 4'b0001);
        txn("rd5_merge", 1'b0, 10'h005, 32'h0, 4'h0);
        txn("wr5_be0", 1'b1, 10'h005, 32'hFFFFFFFF, 4'b0000);
        txn("rd5_be0", 1'b0, 10'h005, 32'h0, 4'h0);

        // Response back-pressure with a pending request held on the channel.
        issue(1'b0, 10'h005, 32'h0, 4'h0);
        wait_rsp("hold_rd");
        held = rsp_rdata;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h010; req_wdata = 32'h0; req_be = 4'hF;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("hold_vld", {31'd0, rsp_valid}, 32'd1);
            check("hold_rdata", rsp_rdata, held);
            check("hold_err", {31'd0, rsp_err}, 32'd0);
            check("hold_noacc", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("hs_vld_clr", {31'd0, rsp_valid}, 32'd0);
        check("hs_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("pend_acc", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        push_exp(1'b1, 10'h010, 32'h0, 4'hF);
        wait_rsp("pend_wr");
        handshake("pend_wr");

        txn("oor_wr", 1'b1, 10'h200, 32'h12345678, 4'hF);
        txn("oor_rd", 1'b0, 10'h200, 32'h0, 4'h0);
        txn("alias0", 1'b0, 10'h000, 32'h0, 4'h0);
        txn("after_oor5", 1'b0, 10'h005, 32'h0, 4'h0);

        // Reset during WAIT of a write: the write must never land.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h010; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("mid_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_ready", {31'd0, req_ready}, 32'd1);
        check("mrst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mrst_rdata", rsp_rdata, 32'd0);
        check("mrst_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        txn("rd10_post_rst", 1'b0, 10'h010, 32'h0, 4'h0);
        txn("rd5_post_rst", 1'b0, 10'h005, 32'h0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
